// File: rtl/conv_layer_ctrl_pkg.sv
// Shared types, data widths and geometry helpers for the convolution layer controller.
package conv_layer_ctrl_pkg;

    localparam int A_DSP_WIDTH = 16;
    localparam int DW          = 16;
    localparam int W_DW        = 18;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        RST_BLK,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    function automatic int calc_out_size(int fm_size, int kernel_size, int padding, int stride);
        return (fm_size - kernel_size + 2 * padding) / stride + 1;
    endfunction

    function automatic int calc_out_cnt(int out_size, int maxpool);
        return (maxpool != 0) ? (out_size / 2) * (out_size / 2) : out_size * out_size;
    endfunction

    // A depth of one still needs a one-bit address so ports never collapse to zero width.
    function automatic int addr_width(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// Layer handshake, BRAM ports and conv_blk connections seen by the layer controller.
interface conv_layer_ctrl_if #(
    parameter int W_AW   = 2,
    parameter int FM_AW  = 6,
    parameter int RES_AW = 6
);
    import conv_layer_ctrl_pkg::*;

    logic                   i_start;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_err;
    logic [W_AW-1:0]        o_w_addr;
    logic [W_DW-1:0]        i_w_rdata;
    logic [FM_AW-1:0]       o_fm_addr;
    logic [A_DSP_WIDTH-1:0] i_fm_rdata;
    logic                   o_blk_rst;
    logic                   o_blk_go;
    logic [A_DSP_WIDTH-1:0] o_fm_data;
    logic [W_DW-1:0]        o_weight_data;
    logic                   i_blk_en;
    logic [DW-1:0]          i_blk_result;
    logic                   o_res_we;
    logic [RES_AW-1:0]      o_res_addr;
    logic [DW-1:0]          o_res_wdata;

    modport master (
        input  i_start, i_w_rdata, i_fm_rdata, i_blk_en, i_blk_result,
        output o_busy, o_done, o_err, o_w_addr, o_fm_addr, o_blk_rst, o_blk_go,
               o_fm_data, o_weight_data, o_res_we, o_res_addr, o_res_wdata
    );

    modport slave (
        output i_start, i_w_rdata, i_fm_rdata, i_blk_en, i_blk_result,
        input  o_busy, o_done, o_err, o_w_addr, o_fm_addr, o_blk_rst, o_blk_go,
               o_fm_data, o_weight_data, o_res_we, o_res_addr, o_res_wdata
    );

endinterface

// File: rtl/conv_layer_ctrl_res_writer.sv
// Collects conv_blk results for one filter and writes them to result BRAM at the filter's offset.
module conv_layer_ctrl_res_writer
    import conv_layer_ctrl_pkg::*;
#(
    parameter int W_AW    = 2,
    parameter int RES_AW  = 6,
    parameter int OUT_CNT = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              capture_en,
    input  logic              clear,
    input  logic [W_AW-1:0]   filter,
    input  logic              blk_en,
    input  logic [DW-1:0]     blk_result,
    output logic              res_we,
    output logic [RES_AW-1:0] res_addr,
    output logic [DW-1:0]     res_wdata,
    output logic              res_full,
    output logic              drop
);

    localparam int CNT_W = $clog2(OUT_CNT + 1);

    logic [CNT_W-1:0]  res_cnt;
    logic [RES_AW-1:0] base_addr;

    assign base_addr = RES_AW'(filter) * RES_AW'(OUT_CNT);
    assign res_full  = (res_cnt == CNT_W'(OUT_CNT));
    assign drop      = capture_en && blk_en && res_full;

    // Results arriving after the filter's quota is met are discarded; the top flags them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            res_cnt   <= '0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_wdata <= '0;
        end else begin
            res_we <= 1'b0;
            if (clear) begin
                res_cnt <= '0;
            end else if (capture_en && blk_en && !res_full) begin
                res_we    <= 1'b1;
                res_addr  <= base_addr + RES_AW'(res_cnt);
                res_wdata <= blk_result;
                res_cnt   <= res_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Sequences one convolution layer through a single conv_blk, one filter at a time.
module conv_layer_ctrl
    import conv_layer_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 8,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int MAXPOOL     = 1,
    parameter int N_FILTERS   = 4,
    parameter int RST_CYC     = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    conv_layer_ctrl_if.master bus
);

    localparam int OUT_SIZE = calc_out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE);
    localparam int OUT_CNT  = calc_out_cnt(OUT_SIZE, MAXPOOL);
    localparam int FM_DEPTH = FM_SIZE * FM_SIZE;
    localparam int FM_AW    = addr_width(FM_DEPTH);
    localparam int RES_AW   = addr_width(N_FILTERS * OUT_CNT);
    localparam int W_AW     = addr_width(N_FILTERS);
    localparam int RST_W    = addr_width(RST_CYC);
    localparam int WD_W     = $clog2(TIMEOUT + 1);

    state_t                 state;
    state_t                 next_state;
    logic [W_AW-1:0]        filter;
    logic [FM_AW-1:0]       fm_addr;
    logic [RST_W-1:0]       rst_cnt;
    logic [WD_W-1:0]        wd_cnt;
    logic                   load_phase;
    logic [W_DW-1:0]        weight_data;
    logic [A_DSP_WIDTH-1:0] fm_data;
    logic                   err;

    logic busy;
    logic done;
    logic blk_rst;
    logic blk_go;
    logic capture_en;
    logic clear_res;
    logic timeout;
    logic res_full;
    logic drop;
    logic last_filter;

    assign last_filter = (filter == W_AW'(N_FILTERS - 1));
    assign timeout     = (state == DRAIN) && !res_full && (wd_cnt == WD_W'(TIMEOUT));

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        blk_rst    = 1'b1;
        blk_go     = 1'b0;
        capture_en = 1'b0;
        clear_res  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.i_start) next_state = LOAD_W;
            end
            LOAD_W: begin
                if (load_phase) next_state = RST_BLK;
            end
            RST_BLK: begin
                if (rst_cnt == RST_W'(RST_CYC - 1)) next_state = STREAM;
            end
            STREAM: begin
                blk_rst    = 1'b0;
                blk_go     = 1'b1;
                capture_en = 1'b1;
                if (fm_addr == FM_AW'(FM_DEPTH - 1)) next_state = DRAIN;
            end
            DRAIN: begin
                blk_rst    = 1'b0;
                blk_go     = 1'b1;
                capture_en = 1'b1;
                if (res_full || timeout) next_state = NEXT;
            end
            NEXT: begin
                clear_res  = 1'b1;
                next_state = last_filter ? DONE : LOAD_W;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Weight is captured on the second LOAD_W cycle, once the BRAM read for this filter has returned.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            filter      <= '0;
            fm_addr     <= '0;
            rst_cnt     <= '0;
            wd_cnt      <= '0;
            load_phase  <= 1'b0;
            weight_data <= '0;
            fm_data     <= '0;
            err         <= 1'b0;
        end else begin
            state   <= next_state;
            fm_data <= bus.i_fm_rdata;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        filter <= '0;
                        err    <= 1'b0;
                    end
                end
                LOAD_W: begin
                    load_phase <= ~load_phase;
                    if (load_phase) weight_data <= bus.i_w_rdata;
                end
                RST_BLK: begin
                    rst_cnt <= (rst_cnt == RST_W'(RST_CYC - 1)) ? '0 : rst_cnt + 1'b1;
                end
                STREAM: begin
                    if (fm_addr != FM_AW'(FM_DEPTH - 1)) fm_addr <= fm_addr + 1'b1;
                end
                DRAIN: begin
                    wd_cnt <= bus.i_blk_en ? '0 : wd_cnt + 1'b1;
                    if (timeout) err <= 1'b1;
                end
                NEXT: begin
                    fm_addr <= '0;
                    wd_cnt  <= '0;
                    if (!last_filter) filter <= filter + 1'b1;
                end
                default: ;
            endcase
            if (drop) err <= 1'b1;
        end
    end

    conv_layer_ctrl_res_writer #(
        .W_AW    (W_AW),
        .RES_AW  (RES_AW),
        .OUT_CNT (OUT_CNT)
    ) u_res_writer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .capture_en (capture_en),
        .clear      (clear_res),
        .filter     (filter),
        .blk_en     (bus.i_blk_en),
        .blk_result (bus.i_blk_result),
        .res_we     (bus.o_res_we),
        .res_addr   (bus.o_res_addr),
        .res_wdata  (bus.o_res_wdata),
        .res_full   (res_full),
        .drop       (drop)
    );

    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_err         = err;
    assign bus.o_w_addr      = filter;
    assign bus.o_fm_addr     = fm_addr;
    assign bus.o_blk_rst     = blk_rst;
    assign bus.o_blk_go      = blk_go;
    assign bus.o_fm_data     = fm_data;
    assign bus.o_weight_data = weight_data;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench for conv_layer_ctrl with BRAM models and a conv_blk stub emitting 100+n.
module tb_conv_layer_ctrl;
    import conv_layer_ctrl_pkg::*;

    // FM 4x4, K=3, no maxpool -> 2x2 outputs, 4 results per filter, 2 filters.
    localparam int N_FILT   = 2;
    localparam int OUT_CNT  = 4;
    localparam int FM_DEPTH = 16;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk;
    logic rst_n;

    conv_layer_ctrl_if #(.W_AW(1), .FM_AW(4), .RES_AW(3)) bus ();

    conv_layer_ctrl #(
        .KERNEL_SIZE (3),
        .FM_SIZE     (4),
        .PADDING     (0),
        .STRIDE      (1),
        .MAXPOOL     (0),
        .N_FILTERS   (N_FILT),
        .RST_CYC     (2),
        .TIMEOUT     (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    wr_t wr_q[$];
    int  fm_q[$];
    int  w_q[$];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int done_cnt  = 0;
    int emit_limit = 4;

    logic [W_DW-1:0] wmem [N_FILT];
    int go_cnt;
    int emit_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Weight and FM BRAMs, one cycle read latency.
    always @(posedge clk) begin
        bus.i_w_rdata  <= wmem[bus.o_w_addr];
        bus.i_fm_rdata <= 16'(200 + int'(bus.o_fm_addr));
    end

    // conv_blk stub: after five cycles of go, emits 100+n once per cycle up to emit_limit.
    always @(posedge clk) begin
        if (!bus.o_blk_go) begin
            go_cnt       <= 0;
            emit_n       <= 0;
            bus.i_blk_en <= 1'b0;
        end else if (go_cnt < 5) begin
            go_cnt       <= go_cnt + 1;
            bus.i_blk_en <= 1'b0;
        end else if (emit_n < emit_limit) begin
            bus.i_blk_en     <= 1'b1;
            bus.i_blk_result <= 16'(100 + emit_n);
            emit_n           <= emit_n + 1;
        end else begin
            bus.i_blk_en <= 1'b0;
        end
    end

    // Monitor: pops expected writes, stream addresses and weights as the DUT presents them.
    initial begin
        int          stream_idx;
        logic        prev_go;
        logic        prev_rst;
        logic [17:0] prev_w;
        wr_t         e;
        int          ea;
        stream_idx = 0;
        prev_go    = 1'b0;
        prev_rst   = 1'b0;
        prev_w     = '0;
        forever begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
            if (bus.o_res_we) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(bus.o_res_addr), 32'hFFFF_FFFF);
                end else begin
                    e = wr_q.pop_front();
                    checkOutput("res_addr", 32'(bus.o_res_addr), 32'(e.addr));
                    checkOutput("res_wdata", 32'(bus.o_res_wdata), 32'(e.data));
                end
            end
            if (bus.o_blk_go) begin
                if (!prev_go) begin
                    checkOutput("rst_before_go", 32'(prev_rst), 32'd1);
                    if (w_q.size() == 0) checkOutput("unexpected_filter", 32'(prev_w), 32'hFFFF_FFFF);
                    else checkOutput("weight_in_rst_blk", 32'(prev_w), 32'(w_q.pop_front()));
                end
                if (stream_idx < FM_DEPTH) begin
                    if (fm_q.size() == 0) begin
                        checkOutput("unexpected_stream", 32'(bus.o_fm_addr), 32'hFFFF_FFFF);
                    end else begin
                        ea = fm_q.pop_front();
                        checkOutput("fm_addr", 32'(bus.o_fm_addr), 32'(ea));
                        if (stream_idx >= 2) checkOutput("fm_data_lag", 32'(bus.o_fm_data), 32'(200 + ea - 2));
                    end
                end
                stream_idx++;
            end else begin
                stream_idx = 0;
            end
            prev_go  = bus.o_blk_go;
            prev_rst = bus.o_blk_rst;
            prev_w   = bus.o_weight_data;
        end
    end

    task automatic applyStimulus(input int emits);
        emit_limit = emits;
        for (int f = 0; f < N_FILT; f++) begin
            w_q.push_back(f == 0 ? 5 : 7);
            for (int a = 0; a < FM_DEPTH; a++) fm_q.push_back(a);
            for (int n = 0; n < emits; n++) wr_q.push_back('{addr: f * OUT_CNT + n, data: 100 + n});
        end
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", 32'(bus.o_busy), 32'd1);
        checkOutput("err_cleared_on_start", 32'(bus.o_err), 32'd0);
    endtask

    task automatic waitDone(input int budget);
        int i;
        i = 0;
        while (!bus.o_done && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput("done_within_budget", 32'(bus.o_done), 32'd1);
    endtask

    task automatic waitStreamAddr(input int addr, input int budget);
        int i;
        i = 0;
        while (!(bus.o_blk_go && int'(bus.o_fm_addr) == addr) && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput("reached_stream_addr", 32'(bus.o_fm_addr), 32'(addr));
    endtask

    task automatic checkRunEnd(input int done_before, input int exp_err);
        repeat (40) @(negedge clk);
        checkOutput("single_done_pulse", 32'(done_cnt - done_before), 32'd1);
        checkOutput("err_at_end", 32'(bus.o_err), 32'(exp_err));
        checkOutput("writes_outstanding", 32'(wr_q.size()), 32'd0);
        checkOutput("stream_outstanding", 32'(fm_q.size()), 32'd0);
        checkOutput("idle_after_done", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        int d0;
        wmem[0]          = 18'd5;
        wmem[1]          = 18'd7;
        rst_n            = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_blk_result = '0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        checkOutput("reset_blk_rst", 32'(bus.o_blk_rst), 32'd1);
        checkOutput("reset_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("reset_done", 32'(bus.o_done), 32'd0);
        checkOutput("reset_err", 32'(bus.o_err), 32'd0);
        checkOutput("reset_res_we", 32'(bus.o_res_we), 32'd0);
        checkOutput("reset_blk_go", 32'(bus.o_blk_go), 32'd0);
        rst_n = 1'b1;

        // Full layer: two filters, weights 5 and 7, writes 0..3 and 4..7.
        d0 = done_cnt;
        applyStimulus(4);
        waitDone(400);
        checkRunEnd(d0, 0);

        // Start re-pulsed mid-stream must be ignored.
        d0 = done_cnt;
        applyStimulus(4);
        waitStreamAddr(5, 100);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        waitDone(400);
        checkRunEnd(d0, 0);

        // Only three results per filter: watchdog expires, error sticks until next start.
        d0 = done_cnt;
        applyStimulus(3);
        waitDone(400);
        checkRunEnd(d0, 1);
        d0 = done_cnt;
        applyStimulus(4);
        waitDone(400);
        checkRunEnd(d0, 0);

        // Reset pulse while streaming address 7 aborts the layer.
        applyStimulus(4);
        waitStreamAddr(7, 100);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr_q.delete();
        fm_q.delete();
        w_q.delete();
        @(negedge clk);
        checkOutput("abort_blk_rst", 32'(bus.o_blk_rst), 32'd1);
        checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("abort_blk_go", 32'(bus.o_blk_go), 32'd0);
        checkOutput("abort_res_we", 32'(bus.o_res_we), 32'd0);
        checkOutput("abort_fm_addr", 32'(bus.o_fm_addr), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("abort_no_writes", 32'(wr_q.size()), 32'd0);

        // Fresh start after the abort runs from filter 0, address 0.
        d0 = done_cnt;
        applyStimulus(4);
        waitDone(400);
        checkRunEnd(d0, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
